// File: rtl/mips_cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_cpu_pkg
// Purpose  : Shared definitions for the multi-cycle MIPS32 bus CPU: FSM state
//            enum, opcode / funct encodings and the boot address.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mips_cpu_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    MEM   = 2'd2,
    HALT  = 2'd3
  } state_e;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  // Primary opcodes
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;

  // SPECIAL funct codes
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

endpackage
`default_nettype wire

// File: rtl/mips_cpu_regfile.sv
`default_nettype none
// ============================================================================
// Module   : mips_cpu_regfile
// Purpose  : 32 x 32-bit register file, two combinational read ports, one
//            synchronous write port, synchronous clear. $0 reads as zero.
// Ports    : clk, reset          - clock, sync active-high clear
//            rs_addr_i/rs_data_o - read port A
//            rt_addr_i/rt_data_o - read port B
//            we_i/waddr_i/wdata_i- write port
//            v0_o                - contents of $2
// Revision : 1.0 - initial release
// ============================================================================
module mips_cpu_regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs_addr_i,
  output logic [31:0] rs_data_o,
  input  logic [4:0]  rt_addr_i,
  output logic [31:0] rt_data_o,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] v0_o
);

  logic [31:0] regs_q [32];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (we_i && (waddr_i != 5'd0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rs_data_o = (rs_addr_i == 5'd0) ? 32'd0 : regs_q[rs_addr_i];
  assign rt_data_o = (rt_addr_i == 5'd0) ? 32'd0 : regs_q[rt_addr_i];
  assign v0_o      = regs_q[2];

endmodule
`default_nettype wire

// File: rtl/mips_cpu_bus.sv
`default_nettype none
// ============================================================================
// Module   : mips_cpu_bus
// Purpose  : Multi-cycle non-pipelined MIPS32 core with one Avalon-MM master
//            shared by instruction fetch and data access. Boots at
//            0xBFC00000 and halts once control transfers to address 0.
// Ports    : clk, reset          - clock, sync active-high reset
//            active              - high while running
//            register_v0         - current $2
//            address/read/write/writedata/byteenable - bus request
//            waitrequest/readdata- bus response
// Revision : 1.0 - initial release
// ============================================================================
module mips_cpu_bus
  import mips_cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic        active,
  output logic [31:0] register_v0,
  output logic [31:0] address,
  output logic        write,
  output logic        read,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, br_target_q, br_target_d;
  logic        br_pending_q, br_pending_d, ir_valid_q, ir_valid_d;

  // readdata only carries the instruction on the first EXEC cycle; a stalled
  // EXEC or the MEM cycle must use the latched copy instead.
  logic [31:0] instr;
  assign instr = ((state_q == MEM) || ir_valid_q) ? ir_q : readdata;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [31:0] imm_s, imm_z, pc_plus4, mem_addr, rs_data, rt_data;
  assign opcode   = instr[31:26];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign shamt    = instr[10:6];
  assign funct    = instr[5:0];
  assign imm_s    = {{16{instr[15]}}, instr[15:0]};
  assign imm_z    = {16'd0, instr[15:0]};
  assign pc_plus4 = pc_q + 32'd4;
  assign mem_addr = rs_data + imm_s;

  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  mips_cpu_regfile u_regfile (
    .clk       (clk),
    .reset     (reset),
    .rs_addr_i (rs),
    .rs_data_o (rs_data),
    .rt_addr_i (rt),
    .rt_data_o (rt_data),
    .we_i      (rf_we),
    .waddr_i   (rf_waddr),
    .wdata_i   (rf_wdata),
    .v0_o      (register_v0)
  );

  // Decode + ALU
  logic [31:0] res, jump_tgt;
  logic [4:0]  dst;
  logic        wr_en, jump, is_lw, is_sw;

  always_comb begin
    res = '0; dst = rd; wr_en = 1'b0; jump = 1'b0; jump_tgt = '0;
    is_lw = 1'b0; is_sw = 1'b0;
    case (opcode)
      OP_SPECIAL: begin
        wr_en = 1'b1;
        case (funct)
          FN_SLL:  res = rt_data << shamt;
          FN_SRL:  res = rt_data >> shamt;
          FN_SRA:  res = $signed(rt_data) >>> shamt;
          FN_JR:   begin wr_en = 1'b0; jump = 1'b1; jump_tgt = rs_data; end
          FN_JALR: begin res = pc_q + 32'd8; jump = 1'b1; jump_tgt = rs_data; end
          FN_ADDU: res = rs_data + rt_data;
          FN_SUBU: res = rs_data - rt_data;
          FN_AND:  res = rs_data & rt_data;
          FN_OR:   res = rs_data | rt_data;
          FN_XOR:  res = rs_data ^ rt_data;
          FN_SLT:  res = {31'd0, $signed(rs_data) < $signed(rt_data)};
          FN_SLTU: res = {31'd0, rs_data < rt_data};
          default: wr_en = 1'b0;
        endcase
      end
      OP_ADDIU: begin wr_en = 1'b1; dst = rt; res = rs_data + imm_s; end
      OP_SLTI:  begin wr_en = 1'b1; dst = rt; res = {31'd0, $signed(rs_data) < $signed(imm_s)}; end
      OP_SLTIU: begin wr_en = 1'b1; dst = rt; res = {31'd0, rs_data < imm_s}; end
      OP_ANDI:  begin wr_en = 1'b1; dst = rt; res = rs_data & imm_z; end
      OP_ORI:   begin wr_en = 1'b1; dst = rt; res = rs_data | imm_z; end
      OP_XORI:  begin wr_en = 1'b1; dst = rt; res = rs_data ^ imm_z; end
      OP_LUI:   begin wr_en = 1'b1; dst = rt; res = {instr[15:0], 16'd0}; end
      OP_BEQ:   begin jump = (rs_data == rt_data); jump_tgt = pc_plus4 + {imm_s[29:0], 2'b00}; end
      OP_BNE:   begin jump = (rs_data != rt_data); jump_tgt = pc_plus4 + {imm_s[29:0], 2'b00}; end
      OP_J:     begin jump = 1'b1; jump_tgt = {pc_plus4[31:28], instr[25:0], 2'b00}; end
      OP_JAL:   begin
        jump = 1'b1; jump_tgt = {pc_plus4[31:28], instr[25:0], 2'b00};
        wr_en = 1'b1; dst = 5'd31; res = pc_q + 32'd8;
      end
      OP_LW:    is_lw = 1'b1;
      OP_SW:    is_sw = 1'b1;
      default:  ;
    endcase
  end

  // FSM next-state and bus outputs
  logic [31:0] pc_next;
  logic        stall;

  always_comb begin
    state_d = state_q; pc_d = pc_q; ir_d = ir_q;
    br_pending_d = br_pending_q; br_target_d = br_target_q;
    ir_valid_d = (state_q == EXEC);
    rf_we = 1'b0; rf_waddr = '0; rf_wdata = '0;
    address = pc_q; read = 1'b0; write = 1'b0; writedata = rt_data;
    active = 1'b1; byteenable = 4'b1111;
    pc_next = br_pending_q ? br_target_q : pc_plus4;
    stall = 1'b0;
    case (state_q)
      FETCH: begin
        read = 1'b1;
        // Written so that an unknown waitrequest lets the fetch proceed.
        state_d = EXEC;
        if (waitrequest) state_d = FETCH;
      end
      EXEC: begin
        ir_d = instr;
        if (is_lw || is_sw) begin
          address = mem_addr;
          read    = is_lw;
          write   = is_sw;
          stall   = waitrequest;
        end
        if (!stall) begin
          pc_d         = pc_next;
          br_pending_d = jump;
          br_target_d  = jump_tgt;
          rf_we        = wr_en;
          rf_waddr     = dst;
          rf_wdata     = res;
          if (is_lw)                 state_d = MEM;
          else if (pc_next == 32'd0) state_d = HALT;
          else                       state_d = FETCH;
        end
      end
      MEM: begin
        rf_we    = 1'b1;
        rf_waddr = ir_q[20:16];
        rf_wdata = readdata;
        state_d  = (pc_q == 32'd0) ? HALT : FETCH;
      end
      HALT: active = 1'b0;
      default: state_d = HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      ir_q         <= '0;
      ir_valid_q   <= 1'b0;
      br_pending_q <= 1'b0;
      br_target_q  <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      ir_valid_q   <= ir_valid_d;
      br_pending_q <= br_pending_d;
      br_target_q  <= br_target_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mips_cpu_bus.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_cpu_bus
// Purpose  : Self-checking bench for mips_cpu_bus. A bus slave model serves
//            instruction/data memory with a configurable wait-state count;
//            expected bus transactions are queued by the stimulus and checked
//            by a monitor whenever the CPU drives read or write.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_cpu_bus;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        active, write, read, waitrequest;
  logic [31:0] register_v0, address, writedata, readdata;
  logic [3:0]  byteenable;

  always #5 clk = ~clk;

  mips_cpu_bus dut (
    .clk         (clk),
    .reset       (reset),
    .active      (active),
    .register_v0 (register_v0),
    .address     (address),
    .write       (write),
    .read        (read),
    .waitrequest (waitrequest),
    .writedata   (writedata),
    .byteenable  (byteenable),
    .readdata    (readdata)
  );

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] data;
  } txn_t;

  txn_t        exp_q[$];
  txn_t        mon_e;
  bit          mon_ok;
  logic [31:0] imem [64];
  logic [31:0] dmem [16];
  logic [31:0] dmem0_init = '0;
  int          ws = 0;
  int          wait_left = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  // ---------------- bus slave ----------------
  assign waitrequest = (read || write) && (wait_left != 0);

  always @(posedge clk) begin
    if (reset) begin
      wait_left <= ws;
      for (int i = 0; i < 16; i++) dmem[i] <= '0;
      dmem[0] <= dmem0_init;
    end else if (read || write) begin
      if (wait_left != 0) begin
        wait_left <= wait_left - 1;
      end else begin
        wait_left <= ws;
        if (write) dmem[address[5:2]] <= writedata;
        else readdata <= (address[31:28] == 4'hB) ? imem[address[7:2]] : dmem[address[5:2]];
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!reset && (read || write)) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL bus_unexpected: got addr=%h rd=%b wr=%b, want no access", address, read, write);
      end else begin
        mon_e  = exp_q[0];
        mon_ok = (address === mon_e.addr) && (write === mon_e.wr) && (read === !mon_e.wr) &&
                 (byteenable === 4'b1111) && (!mon_e.wr || (writedata === mon_e.data));
        if (mon_ok) n_pass++;
        else $display("FAIL bus_txn: got addr=%h rd=%b wr=%b wdata=%h, want addr=%h rd=%b wr=%b wdata=%h",
                      address, read, write, writedata, mon_e.addr, !mon_e.wr, mon_e.wr, mon_e.data);
        if (!waitrequest) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h", name, got, want);
  endtask

  function automatic void push_r(input logic [31:0] a);
    txn_t t;
    t.addr = a; t.wr = 1'b0; t.data = '0;
    exp_q.push_back(t);
  endfunction

  function automatic void push_w(input logic [31:0] a, input logic [31:0] d);
    txn_t t;
    t.addr = a; t.wr = 1'b1; t.data = d;
    exp_q.push_back(t);
  endfunction

  task automatic do_reset(input int wsv);
    ws = wsv;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
  endtask

  // lw $3,1($0) ; jr $0 ; addiu $2,$3,0 (delay slot)
  task automatic load_a();
    imem[0] = 32'h8C030001;
    imem[1] = 32'h00000008;
    imem[2] = 32'h24620000;
    dmem0_init = 32'd192;
  endtask

  task automatic push_a();
    push_r(32'hBFC00000); push_r(32'h00000001);
    push_r(32'hBFC00004); push_r(32'hBFC00008);
  endtask

  task automatic load_b();
    logic [31:0] prog[$] = '{
      32'h34031234,   // ori   $3,$0,0x1234
      32'hAC030008,   // sw    $3,8($0)
      32'h10000002,   // beq   $0,$0,2  -> 0xBFC00014
      32'h2402FFFF,   // addiu $2,$0,-1 (delay slot)
      32'h24020005,   // addiu $2,$0,5  (skipped)
      32'hAC020004,   // sw    $2,4($0)
      32'h8C020008,   // lw    $2,8($0)
      32'h00032023,   // subu  $4,$0,$3
      32'h00042903,   // sra   $5,$4,4
      32'hAC05000C,   // sw    $5,12($0)
      32'h00A0102A,   // slt   $2,$5,$0
      32'hAC020010,   // sw    $2,16($0)
      32'h00003009,   // jalr  $6,$0
      32'h00C01025    // or    $2,$6,$0 (delay slot)
    };
    foreach (prog[i]) imem[i] = prog[i];
    dmem0_init = '0;
  endtask

  task automatic push_b();
    push_r(32'hBFC00000); push_r(32'hBFC00004); push_w(32'h8, 32'h00001234);
    push_r(32'hBFC00008); push_r(32'hBFC0000C); push_r(32'hBFC00014);
    push_w(32'h4, 32'hFFFFFFFF); push_r(32'hBFC00018); push_r(32'h8);
    push_r(32'hBFC0001C); push_r(32'hBFC00020); push_r(32'hBFC00024);
    push_w(32'hC, 32'hFFFFFEDC); push_r(32'hBFC00028); push_r(32'hBFC0002C);
    push_w(32'h10, 32'h00000001); push_r(32'hBFC00030); push_r(32'hBFC00034);
  endtask

  // Counts edges after the reset edge until active drops (bounded).
  task automatic run_to_halt(input string name, input int exp_cyc, input logic [31:0] exp_v0);
    int cyc;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while ((active === 1'b1) && (cyc < 400));
    check({name, "_cycles"}, 32'(cyc), 32'(exp_cyc));
    check({name, "_v0"}, register_v0, exp_v0);
    check({name, "_halt_rdwr"}, {30'd0, read, write}, 32'd0);
    check({name, "_queue_left"}, 32'(exp_q.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check({name, "_halt_held"}, {31'd0, active}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 64; i++) imem[i] = '0;

    // Reset state and the basic load / jr $0 / delay-slot halt program
    load_a();
    do_reset(0);
    push_a();
    @(negedge clk);
    check("rst_active", {31'd0, active}, 32'd1);
    check("rst_read", {31'd0, read}, 32'd1);
    check("rst_write", {31'd0, write}, 32'd0);
    check("rst_address", address, 32'hBFC00000);
    check("rst_byteenable", {28'd0, byteenable}, 32'hF);
    check("rst_v0", register_v0, 32'd0);
    run_to_halt("prog_a", 7, 32'd192);

    // Same program with 3 wait states on every access
    do_reset(3);
    push_a();
    run_to_halt("prog_a_ws3", 19, 32'd192);

    // Stores, taken branch with delay slot, ALU ops, jalr to 0
    load_b();
    do_reset(0);
    push_b();
    run_to_halt("prog_b", 27, 32'hBFC00038);

    // Reset while the load in EXEC is stalled
    load_a();
    do_reset(3);
    push_a();
    repeat (5) @(posedge clk);
    #1;
    check("mid_lw_address", address, 32'h00000001);
    check("mid_lw_read", {31'd0, read}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    push_a();
    check("post_rst_address", address, 32'hBFC00000);
    check("post_rst_rdwr", {30'd0, read, write}, 32'd2);
    check("post_rst_v0", register_v0, 32'd0);
    run_to_halt("prog_a_rst", 19, 32'd192);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
